uart_rx_conditioner: RTL and testbench

Front-end conditioner for the raw serial receive pin, placed between the board pin and the 16550 UART `sin` input of the SoC sub-system.
- Synchronises the asynchronous pin into clk_50 and rejects short glitches with a consecutive-sample filter.
- Classifies the line as idle, active or break.
- Produces a pulse-stretched activity flag suitable for a user LED.

---
 rtl/uart_rx_conditioner.sv | 153 +++++++++++++++
 tb/tb_uart_rx_conditioner.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_conditioner.sv
// Receive-pin front end: synchroniser, consecutive-sample glitch filter,
// idle/active/break line classifier and a stretched activity flag.
module uart_rx_conditioner #(
  parameter int SYNC_STAGES  = 2,
  parameter int FILT_LEN     = 4,
  parameter int BREAK_CYCLES = 5000,
  parameter int IDLE_CYCLES  = 4340,
  parameter int ACT_STRETCH  = 2500000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       uart_rx_in,
  input  logic       glitch_clr,
  output logic       rx_filt,
  output logic       line_idle,
  output logic       break_active,
  output logic       break_pulse,
  output logic [7:0] glitch_cnt,
  output logic       activity
);

  localparam int DIFF_W  = $clog2(FILT_LEN);
  localparam int RUN_MAX = (BREAK_CYCLES > IDLE_CYCLES) ? BREAK_CYCLES : IDLE_CYCLES;
  localparam int RUN_W   = $clog2(RUN_MAX) + 1;
  localparam int ACT_W   = $clog2(ACT_STRETCH + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_BREAK  = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  logic                   rx_filt_q, rx_filt_d;
  logic [DIFF_W-1:0]      diff_cnt_q, diff_cnt_d;
  logic                   glitch_inc;
  logic [7:0]             glitch_cnt_q, glitch_cnt_d;
  logic [RUN_W-1:0]       run_cnt_q, run_cnt_d;
  logic [1:0]             state_q, state_d;
  logic                   line_idle_q, line_idle_d;
  logic                   break_active_q, break_active_d;
  logic                   break_pulse_q, break_pulse_d;
  logic [ACT_W-1:0]       act_cnt_q, act_cnt_d;
  logic                   rx_fall;

  // Synchroniser and filter: a disagreement run shorter than FILT_LEN is a glitch.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], uart_rx_in};
    s          = sync_q[SYNC_STAGES-1];
    rx_filt_d  = rx_filt_q;
    diff_cnt_d = diff_cnt_q;
    glitch_inc = 1'b0;
    if (s != rx_filt_q) begin
      if (diff_cnt_q == DIFF_W'(FILT_LEN - 1)) begin
        rx_filt_d  = s;
        diff_cnt_d = '0;
      end else begin
        diff_cnt_d = diff_cnt_q + DIFF_W'(1);
      end
    end else if (diff_cnt_q != '0) begin
      diff_cnt_d = '0;
      glitch_inc = 1'b1;
    end
  end

  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (glitch_clr) begin
      glitch_cnt_d = '0;
    end else if (glitch_inc && (glitch_cnt_q != 8'hFF)) begin
      glitch_cnt_d = glitch_cnt_q + 8'd1;
    end
  end

  // Run length of the current rx_filt level, saturating at the longest threshold.
  always_comb begin
    rx_fall = rx_filt_q & ~rx_filt_d;
    if (rx_filt_d != rx_filt_q) begin
      run_cnt_d = '0;
    end else if (run_cnt_q == RUN_W'(RUN_MAX)) begin
      run_cnt_d = run_cnt_q;
    end else begin
      run_cnt_d = run_cnt_q + RUN_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_filt_q) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (rx_filt_q && (run_cnt_q >= RUN_W'(IDLE_CYCLES - 1))) begin
          state_d = ST_IDLE;
        end else if (!rx_filt_q && (run_cnt_q >= RUN_W'(BREAK_CYCLES - 1))) begin
          state_d = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rx_filt_q) state_d = ST_ACTIVE;
      end
      default: state_d = ST_IDLE;
    endcase
    line_idle_d    = (state_d == ST_IDLE);
    break_active_d = (state_d == ST_BREAK);
    break_pulse_d  = (state_d == ST_BREAK) && (state_q != ST_BREAK);
  end

  // Retriggerable activity stretch, reloaded on every falling edge of rx_filt.
  always_comb begin
    if (rx_fall) begin
      act_cnt_d = ACT_W'(ACT_STRETCH);
    end else if (act_cnt_q != '0) begin
      act_cnt_d = act_cnt_q - ACT_W'(1);
    end else begin
      act_cnt_d = act_cnt_q;
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      sync_q         <= '1;
      rx_filt_q      <= 1'b1;
      diff_cnt_q     <= '0;
      glitch_cnt_q   <= '0;
      run_cnt_q      <= '0;
      state_q        <= ST_IDLE;
      line_idle_q    <= 1'b1;
      break_active_q <= 1'b0;
      break_pulse_q  <= 1'b0;
      act_cnt_q      <= '0;
    end else begin
      sync_q         <= sync_d;
      rx_filt_q      <= rx_filt_d;
      diff_cnt_q     <= diff_cnt_d;
      glitch_cnt_q   <= glitch_cnt_d;
      run_cnt_q      <= run_cnt_d;
      state_q        <= state_d;
      line_idle_q    <= line_idle_d;
      break_active_q <= break_active_d;
      break_pulse_q  <= break_pulse_d;
      act_cnt_q      <= act_cnt_d;
    end
  end

  assign rx_filt      = rx_filt_q;
  assign line_idle    = line_idle_q;
  assign break_active = break_active_q;
  assign break_pulse  = break_pulse_q;
  assign glitch_cnt   = glitch_cnt_q;
  assign activity     = (act_cnt_q != '0);

endmodule

// File: tb/tb_uart_rx_conditioner.sv
// Directed bench for uart_rx_conditioner: rx_filt is scoreboarded against the
// pin waveform delayed by the fixed latency; line state and counters are checked at known cycles.
module tb_uart_rx_conditioner;

  localparam int LAT = 6;
  localparam int ACT = 16;
  localparam int BRK = 5000;
  localparam int IDL = 4340;
  localparam int BIT = 434;

  logic       clk_50 = 1'b0;
  logic       reset;
  logic       uart_rx_in;
  logic       glitch_clr;
  logic       rx_filt;
  logic       line_idle;
  logic       break_active;
  logic       break_pulse;
  logic [7:0] glitch_cnt;
  logic       activity;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  int bp_count = 0;
  int bp_at    = 0;
  logic [0:0] exp_q[$];

  uart_rx_conditioner #(
    .SYNC_STAGES (2),
    .FILT_LEN    (4),
    .BREAK_CYCLES(BRK),
    .IDLE_CYCLES (IDL),
    .ACT_STRETCH (ACT)
  ) dut (
    .clk_50      (clk_50),
    .reset       (reset),
    .uart_rx_in  (uart_rx_in),
    .glitch_clr  (glitch_clr),
    .rx_filt     (rx_filt),
    .line_idle   (line_idle),
    .break_active(break_active),
    .break_pulse (break_pulse),
    .glitch_cnt  (glitch_cnt),
    .activity    (activity)
  );

  always #10 clk_50 = ~clk_50;

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_50);
    #1;
    cyc_n++;
    if (break_pulse) begin
      bp_count++;
      bp_at = cyc_n;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_prime(input logic v);
    exp_q.delete();
    repeat (LAT - 1) exp_q.push_back(v);
  endtask

  task automatic sb_cycle(input logic v);
    logic [0:0] e;
    uart_rx_in = v;
    exp_q.push_back(v);
    step();
    e = exp_q.pop_front();
    check("rx_filt_sb", 32'(rx_filt), 32'(e));
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    uart_rx_in = 1'b1;
    glitch_clr = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    step();
  endtask

  task automatic glitch_pulse(input int low_n, input int high_n);
    uart_rx_in = 1'b0;
    repeat (low_n) step();
    uart_rx_in = 1'b1;
    repeat (high_n) step();
  endtask

  initial begin
    logic [9:0] frame;
    int low_seen;

    reset      = 1'b1;
    uart_rx_in = 1'b1;
    glitch_clr = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset applied mid-stream with the pin low
    uart_rx_in = 1'b0;
    repeat (10) step();
    check("pre_rst_rx_filt", 32'(rx_filt), 32'd0);
    check("pre_rst_line_idle", 32'(line_idle), 32'd0);
    check("pre_rst_activity", 32'(activity), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_rx_filt", 32'(rx_filt), 32'd1);
    check("rst_line_idle", 32'(line_idle), 32'd1);
    check("rst_break_active", 32'(break_active), 32'd0);
    check("rst_break_pulse", 32'(break_pulse), 32'd0);
    check("rst_glitch_cnt", 32'(glitch_cnt), 32'd0);
    check("rst_activity", 32'(activity), 32'd0);
    step();
    step();
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("rst_rel_rx_filt", 32'(rx_filt), 32'(i < LAT));
    end

    // Latency and activity stretch
    do_reset();
    sb_prime(1'b1);
    cyc_n    = 0;
    bp_count = 0;
    for (int i = 1; i <= 30; i++) begin
      sb_cycle((i <= 20) ? 1'b0 : 1'b1);
      check("lat_line_idle", 32'(line_idle), 32'(i <= LAT));
      check("lat_activity", 32'(activity), 32'((i >= LAT) && (i < LAT + ACT)));
    end
    check("lat_no_break_pulse", 32'(bp_count), 32'd0);

    // Glitch rejection and glitch counter
    do_reset();
    check("glitch_start", 32'(glitch_cnt), 32'd0);
    uart_rx_in = 1'b0;
    repeat (3) step();
    uart_rx_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("glitch3_rx_filt", 32'(rx_filt), 32'd1);
    end
    check("glitch3_cnt", 32'(glitch_cnt), 32'd1);

    low_seen   = 0;
    uart_rx_in = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 5) uart_rx_in = 1'b1;
      step();
      if (rx_filt == 1'b0) low_seen++;
    end
    check("pulse4_low_cycles", 32'(low_seen), 32'd4);
    check("pulse4_no_glitch", 32'(glitch_cnt), 32'd1);

    for (int p = 0; p < 300; p++) begin
      glitch_pulse(3, 5);
      if (p == 99) check("glitch_101", 32'(glitch_cnt), 32'd101);
    end
    check("glitch_sat", 32'(glitch_cnt), 32'd255);

    glitch_pulse(3, 2);
    check("pre_clr_cnt", 32'(glitch_cnt), 32'd255);
    glitch_clr = 1'b1;
    step();
    glitch_clr = 1'b0;
    check("clr_wins", 32'(glitch_cnt), 32'd0);
    repeat (3) step();
    check("clr_holds", 32'(glitch_cnt), 32'd0);
    glitch_pulse(3, 5);
    check("post_clr_count", 32'(glitch_cnt), 32'd1);

    // Break detection and recovery
    do_reset();
    sb_prime(1'b1);
    cyc_n    = 0;
    bp_count = 0;
    for (int i = 1; i <= 5100; i++) begin
      sb_cycle(1'b0);
      if (i == LAT + BRK - 1) check("brk_not_yet", 32'(break_active), 32'd0);
      if (i == LAT + BRK) begin
        check("brk_active", 32'(break_active), 32'd1);
        check("brk_pulse_hi", 32'(break_pulse), 32'd1);
      end
      if (i == LAT + BRK + 1) check("brk_pulse_lo", 32'(break_pulse), 32'd0);
    end
    check("brk_pulse_count", 32'(bp_count), 32'd1);
    check("brk_pulse_at", 32'(bp_at), 32'(LAT + BRK));
    check("brk_hold", 32'(break_active), 32'd1);
    for (int j = 1; j <= 4350; j++) begin
      sb_cycle(1'b1);
      if (j == LAT) check("brk_still", 32'(break_active), 32'd1);
      if (j == LAT + 1) check("brk_cleared", 32'(break_active), 32'd0);
      if (j == LAT + IDL - 1) check("brk_idle_not_yet", 32'(line_idle), 32'd0);
      if (j == LAT + IDL) check("brk_idle_back", 32'(line_idle), 32'd1);
    end
    check("brk_pulse_once", 32'(bp_count), 32'd1);

    // Frame 0x55, 8N1, LSB first
    do_reset();
    sb_prime(1'b1);
    bp_count = 0;
    frame    = {1'b1, 8'h55, 1'b0};
    for (int b = 0; b < 9; b++) begin
      for (int c = 0; c < BIT; c++) sb_cycle(frame[b]);
    end
    check("frame_active", 32'(line_idle), 32'd0);
    for (int k = 1; k <= 4350; k++) begin
      sb_cycle(1'b1);
      if (k == LAT + IDL - 1) check("frame_idle_not_yet", 32'(line_idle), 32'd0);
      if (k == LAT + IDL) check("frame_idle_back", 32'(line_idle), 32'd1);
    end
    check("frame_glitch_cnt", 32'(glitch_cnt), 32'd0);
    check("frame_no_break", 32'(bp_count), 32'd0);

    // Reset while in break with the pin still low
    do_reset();
    sb_prime(1'b1);
    for (int i = 1; i <= 5010; i++) sb_cycle(1'b0);
    check("mid_brk_entered", 32'(break_active), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_break_active", 32'(break_active), 32'd0);
    check("mid_rst_line_idle", 32'(line_idle), 32'd1);
    check("mid_rst_rx_filt", 32'(rx_filt), 32'd1);
    step();
    step();
    reset = 1'b0;
    sb_prime(1'b1);
    cyc_n    = 0;
    bp_count = 0;
    for (int i = 1; i <= 5010; i++) begin
      sb_cycle(1'b0);
      if (i == LAT) check("mid_idle_still", 32'(line_idle), 32'd1);
      if (i == LAT + 1) check("mid_active_again", 32'(line_idle), 32'd0);
      if (i == LAT + BRK - 1) check("mid_brk_not_yet", 32'(break_active), 32'd0);
      if (i == LAT + BRK) check("mid_brk_again", 32'(break_active), 32'd1);
    end
    check("mid_brk_pulse_count", 32'(bp_count), 32'd1);
    check("mid_brk_pulse_at", 32'(bp_at), 32'(LAT + BRK));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
